// File: rtl/r5_pkg.sv
// rtl/r5_pkg.sv - shared constants and digit-reverse addressing for the radix-5 reorder block
// Contents: RADIX, N_PT (frame length), DW_DEFAULT (component width), AW (address width),
//           digit_rev(k) mapping input index k = 5*k1 + k0 to bank address 5*k0 + k1.
package r5_pkg;

  localparam int RADIX      = 5;
  localparam int N_PT       = 25;
  localparam int DW_DEFAULT = 32;
  localparam int AW         = 5;

  // Swap the two base-5 digits of k.
  function automatic logic [AW-1:0] digit_rev(input logic [AW-1:0] k);
    logic [AW-1:0] k1;
    logic [AW-1:0] k0;
    k1 = k / AW'(RADIX);
    k0 = k % AW'(RADIX);
    return k0 * AW'(RADIX) + k1;
  endfunction

endpackage

// File: rtl/r5_bank.sv
// rtl/r5_bank.sv - one 25-entry complex sample bank
// Ports: clk            clock
//        we             write enable
//        waddr, wdata   write address and packed {img, re} sample
//        raddr, rdata   combinational read address and packed {img, re} sample
// Storage is intentionally not reset.
module r5_bank
  import r5_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [2*DW-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [2*DW-1:0] rdata
);

  logic [2*DW-1:0] mem_q [N_PT];
  logic [2*DW-1:0] mem_d [N_PT];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/r5_reorder_25.sv
// rtl/r5_reorder_25.sv - 25-point radix-5 digit-reversed to natural order reorder buffer
// Ports: clk, rst (async, active high)
//        in_valid / in_ready / in_re / in_img      input stream, FFT (digit-reversed) order
//        out_valid / out_ready / out_re / out_img  output stream, natural order
//        out_last                                  final sample (index 24) of a frame
//        ovf                                       sticky overflow, only with R5_REORDER_OVF_EN
// Optional feature macro: R5_REORDER_OVF_EN
module r5_reorder_25
  import r5_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int N  = N_PT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_img,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_img,
  input  logic          out_ready,
  output logic          out_last
`ifdef R5_REORDER_OVF_EN
  ,
  output logic          ovf
`endif
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [AW-1:0]   rcnt_q, rcnt_d;
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [1:0]      full_q, full_d;

  logic            wr_fire;
  logic            rd_fire;
  logic [1:0]      bank_we;
  logic [AW-1:0]   waddr;
  logic [2*DW-1:0] wdata;
  logic [2*DW-1:0] rdata0;
  logic [2*DW-1:0] rdata1;
  logic [2*DW-1:0] rdata;

  always_comb begin
    in_ready  = ~full_q[wbank_q];
    wr_fire   = in_valid & in_ready;
    out_valid = full_q[rbank_q];
    rd_fire   = out_valid & out_ready;
    out_last  = out_valid & (rcnt_q == LAST_IDX);

    waddr   = digit_rev(wcnt_q);
    wdata   = {in_img, in_re};
    bank_we = {wr_fire & wbank_q, wr_fire & ~wbank_q};

    rdata   = rbank_q ? rdata1 : rdata0;
    out_re  = out_valid ? rdata[DW-1:0]    : '0;
    out_img = out_valid ? rdata[2*DW-1:DW] : '0;
  end

  // Writer and reader always own different banks, so a fill completing and a
  // drain completing on the same edge touch different full flags.
  always_comb begin
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    full_d  = full_q;

    if (wr_fire) begin
      if (wcnt_q == LAST_IDX) begin
        wcnt_d          = '0;
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end else begin
        wcnt_d = wcnt_q + AW'(1);
      end
    end

    if (rd_fire) begin
      if (rcnt_q == LAST_IDX) begin
        rcnt_d          = '0;
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end else begin
        rcnt_d = rcnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      full_q  <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      full_q  <= full_d;
    end
  end

`ifdef R5_REORDER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (in_valid & ~in_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  r5_bank #(.DW(DW)) u_bank0 (
    .clk   (clk),
    .we    (bank_we[0]),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rcnt_q),
    .rdata (rdata0)
  );

  r5_bank #(.DW(DW)) u_bank1 (
    .clk   (clk),
    .we    (bank_we[1]),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rcnt_q),
    .rdata (rdata1)
  );

endmodule

// File: tb/tb_r5_reorder_25.sv
// tb/tb_r5_reorder_25.sv - scoreboard bench for the 25-point radix-5 reorder buffer
module tb_r5_reorder_25;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_img = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_img;
  logic          out_ready = 1'b0;
  logic          out_last;
`ifdef R5_REORDER_OVF_EN
  logic          ovf;
`endif

  r5_reorder_25 #(.DW(DW), .N(25)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_re     (in_re),
    .in_img    (in_img),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_img   (out_img),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef R5_REORDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int            out_cyc_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            mon_count = 0;
  int            last_count = 0;
  int            rdy_mode = 0;
  int            fcnt = 0;
  logic [DW-1:0] fr_re [25];
  logic [DW-1:0] fr_im [25];
  logic [DW-1:0] nat_re [25];
  logic [DW-1:0] nat_im [25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = always ready, 1 = stalled, 2 = random 50%.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model: collect a frame in arrival order; sample k = 5*k1+k0
  // belongs at natural position 5*k0+k1. Expected outputs go on the queue.
  always @(negedge clk) begin
    if (rst) begin
      fcnt = 0;
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      fr_re[fcnt] = in_re;
      fr_im[fcnt] = in_img;
      fcnt++;
      if (fcnt == 25) begin
        for (int k = 0; k < 25; k++) begin
          nat_re[5 * (k % 5) + k / 5] = fr_re[k];
          nat_im[5 * (k % 5) + k / 5] = fr_im[k];
        end
        for (int n = 0; n < 25; n++) begin
          exp_q.push_back('{nat_re[n], nat_im[n], (n == 24)});
        end
        fcnt = 0;
      end
    end
  end

  // Monitor: every output handshake is popped against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got re %0h with empty scoreboard", out_re);
        end else begin
          e = exp_q.pop_front();
          chk("out_re", 64'(out_re), 64'(e.re));
          chk("out_img", 64'(out_img), 64'(e.im));
          chk("out_last", 64'(out_last), 64'(e.last));
        end
        mon_count++;
        out_cyc_q.push_back(cyc);
        if (out_last) last_count++;
      end else if (!out_valid) begin
        chk("idle_re_zero", 64'(out_re), 64'(0));
        chk("idle_img_zero", 64'(out_img), 64'(0));
        chk("idle_last_low", 64'(out_last), 64'(0));
      end
    end
  end

  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, output int waits);
    in_valid = 1'b1;
    in_re    = re;
    in_img   = im;
    waits    = 0;
    while (!in_ready && waits < 200) begin
      @(posedge clk);
      #1;
      waits++;
    end
    if (waits >= 200) begin
      chk("send_timeout", 64'(in_ready), 64'(1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < max_cycles) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", 64'(t < max_cycles), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int drops;
    int m0;
    int l0;
    int seq;
    logic acc;

    // Reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_re", 64'(out_re), 64'(0));
    chk("rst_out_img", 64'(out_img), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single frame re=k, img=100+k; first output one cycle after last write
    m0 = mon_count;
    for (int k = 0; k < 25; k++) begin
      in_valid = 1'b1;
      in_re    = DW'(k);
      in_img   = DW'(100 + k);
      chk("t1_in_ready", 64'(in_ready), 64'(1));
      if (k == 24) chk("t1_not_valid_early", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("t1_latency_valid", 64'(out_valid), 64'(1));
    chk("t1_first_re", 64'(out_re), 64'(0));
    chk("t1_first_img", 64'(out_img), 64'(100));
    wait_drain(200);
    chk("t1_count", 64'(mon_count - m0), 64'(25));

    // Three frames streamed, no backpressure, no gap
    m0 = mon_count;
    drops = 0;
    out_cyc_q.delete();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 25; k++) begin
        send(DW'(f * 1000 + k), $urandom, w);
        drops += w;
      end
    end
    wait_drain(200);
    chk("t2_in_ready_drops", 64'(drops), 64'(0));
    chk("t2_count", 64'(mon_count - m0), 64'(75));
    if (out_cyc_q.size() == 75) begin
      chk("t2_no_gap", 64'(out_cyc_q[74] - out_cyc_q[0]), 64'(74));
    end

    // Stall downstream for 60 cycles with input held valid
    rdy_mode = 1;
    @(posedge clk);
    #1;
    m0  = mon_count;
    seq = 0;
    for (int c = 0; c < 60; c++) begin
      in_valid = 1'b1;
      in_re    = DW'(seq);
      in_img   = DW'(seq + 500);
      acc      = in_ready;
      if (out_valid) chk("t3_hold_re", 64'(out_re), 64'(0));
      @(posedge clk);
      #1;
      if (acc) seq++;
    end
    chk("t3_accepts", 64'(seq), 64'(50));
    chk("t3_in_ready_low", 64'(in_ready), 64'(0));
    chk("t3_out_valid_held", 64'(out_valid), 64'(1));
    chk("t3_out_img_held", 64'(out_img), 64'(500));
    in_valid = 1'b0;
    rdy_mode = 0;
    wait_drain(300);
    chk("t3_count", 64'(mon_count - m0), 64'(50));

    // Random valid/ready over 20 frames
    rdy_mode = 2;
    m0 = mon_count;
    l0 = last_count;
    for (int i = 0; i < 500; i++) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_re    = $urandom;
        in_img   = $urandom;
        @(posedge clk);
        #1;
      end
      send($urandom, $urandom, w);
    end
    wait_drain(20000);
    chk("t4_count", 64'(mon_count - m0), 64'(500));
    chk("t4_last_count", 64'(last_count - l0), 64'(20));
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Reset in the middle of a frame
    for (int k = 0; k < 12; k++) send(DW'(7000 + k), DW'(8000 + k), w);
    rst = 1'b1;
    #1;
    chk("t5_out_valid", 64'(out_valid), 64'(0));
    chk("t5_in_ready", 64'(in_ready), 64'(1));
    chk("t5_out_last", 64'(out_last), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m0 = mon_count;
    for (int k = 0; k < 25; k++) send(DW'(9000 + k), DW'(9500 + k), w);
    wait_drain(200);
    chk("t5_count", 64'(mon_count - m0), 64'(25));

`ifdef R5_REORDER_OVF_EN
    // Sticky overflow when pushing into two full banks
    rdy_mode = 1;
    @(posedge clk);
    #1;
    chk("t6_ovf_clear", 64'(ovf), 64'(0));
    for (int k = 0; k < 50; k++) send(DW'(k), DW'(k), w);
    chk("t6_full_in_ready", 64'(in_ready), 64'(0));
    chk("t6_ovf_before", 64'(ovf), 64'(0));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_ovf_set", 64'(ovf), 64'(1));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    wait_drain(300);
    chk("t6_ovf_sticky", 64'(ovf), 64'(1));
    rst = 1'b1;
    #1;
    chk("t6_ovf_rst", 64'(ovf), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
